// File: rtl/load_store_unit_if.sv
// Bus bundle between the core execute stage, the load/store unit and the
// word-indexed data memory.
//   req_*  : request handshake from the core (valid/ready) with store flag,
//            RV32I funct3, byte address and store data
//   resp_* : one-cycle completion pulse with extended load data and error flag
//   mem_*  : word index, write word, write enable, combinational read data
// Modports: slave = the load/store unit's view, master = core + memory view.
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes byte-addressed RV32I load/store requests from the
// core, turns them into word-indexed data memory accesses and returns the
// sign/zero-extended load data. The memory has no byte enables, so sb/sh are
// performed as read-modify-write.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : request handshake, response pulse and memory port
//                 (see load_store_unit_if)
// Optional feature macro LSU_PERF_CNT_EN adds load_cnt/store_cnt/err_cnt,
// 32-bit wrapping counts of completed responses by kind.
module load_store_unit #(
  parameter int MEM_AW = 6,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

  state_t      state;
  logic        st_store;
  logic [2:0]  st_f3;
  logic [1:0]  st_off;
  logic [15:0] st_wdata;

  // Address bits above the word index are ignored (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:MEM_AW+2];

  // Misaligned halfword/word or a funct3 with no meaning for loads/stores.
  function automatic logic is_err(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: is_err = 1'b0;
      3'b001, 3'b101: is_err = off[0];
      3'b010:         is_err = (off != 2'b00);
      default:        is_err = 1'b1;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0]      f3,
                                                   input logic [1:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] word,
                                                  input logic [15:0]     wdata,
                                                  input logic            half,
                                                  input logic [1:0]      off);
    logic [XLEN-1:0] m;
    m = word;
    if (half) m[{off[1], 4'b0000} +: 16] = wdata;
    else      m[{off, 3'b000} +: 8]      = wdata[7:0];
    store_merge = m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            st_store      <= bus.req_store;
            st_f3         <= bus.req_funct3;
            st_off        <= bus.req_addr[1:0];
            st_wdata      <= bus.req_wdata[15:0];
            bus.mem_addr  <= bus.req_addr[MEM_AW+1:2];
            bus.req_ready <= 1'b0;
            if (is_err(bus.req_funct3, bus.req_addr[1:0])) begin
              // Rejected without touching memory: respond next cycle.
              bus.resp_rdata <= '0;
              bus.resp_err   <= 1'b1;
              bus.resp_valid <= 1'b1;
              state          <= DONE;
            end else if (!bus.req_store) begin
              state <= RD;
            end else if (bus.req_funct3[1:0] == 2'b10) begin
              // Full word store needs no read: write immediately.
              bus.mem_wdata <= bus.req_wdata;
              bus.mem_we    <= 1'b1;
              state         <= WR;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        RD: begin
          bus.resp_rdata <= load_extract(bus.mem_rdata, st_f3, st_off);
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        RMW_RD: begin
          bus.mem_wdata <= store_merge(bus.mem_rdata, st_wdata, st_f3[0], st_off);
          bus.mem_we    <= 1'b1;
          state         <= WR;
        end
        WR: begin
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else if (state == DONE) begin
      if (bus.resp_err)  err_cnt   <= err_cnt + 32'd1;
      else if (st_store) store_cnt <= store_cnt + 32'd1;
      else               load_cnt  <= load_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access unit between the single-cycle core's execute stage and the word-indexed data memory.
- Accepts load/store requests with byte address and funct3, converts them to word-indexed memory accesses, and returns the extended load data.
- Memory has no byte enables, so sub-word stores are done as read-modify-write (RMW).
- Multi-cycle FSM with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- MEM_AW, 6, word-index width of the data memory (64 words)
- XLEN, 32, data/address width

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept; high only in IDLE
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  input  XLEN  byte address
- req_wdata  input  XLEN  store data (LSBs used for b/h)
- resp_valid  output  1  one-cycle pulse, request complete
- resp_rdata  output  XLEN  extended load data, valid with resp_valid
- resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  output  MEM_AW  word index to data memory
- mem_wdata  output  XLEN  full word to write
- mem_we  output  1  memory write enable
- mem_rdata  input  XLEN  combinational read data for mem_addr

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Accept: req_valid & req_ready at a posedge latches store, funct3, addr, wdata. Inputs are don't-care after acceptance.
- Address mapping: mem_addr = latched addr[MEM_AW+1:2]. Upper bits are ignored, so out-of-range addresses wrap modulo 2^MEM_AW words. byte_off = addr[1:0].
- Error check at accept:
  - h/hu with addr[0]=1, w with addr[1:0]!=0, or funct3 in {011,110,111} is an error.
  - On error the unit goes to DONE with resp_err=1 and resp_rdata=0. There is no memory access and mem_we is never asserted.
  - Error response latency is 1 cycle after accept.
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
- IDLE: accept -> RD (loads), WR (sw), RMW_RD (sb/sh), DONE (error).
- RD:
  - mem_addr is driven and mem_rdata is sampled at the posedge.
  - Extraction:
    - b/bu select byte byte_off.
    - h/hu select the halfword at addr[1].
    - b/h sign-extend; bu/hu zero-extend; w passes the word through.
  - Result goes to resp_rdata; next state DONE.
- RMW_RD:
  - Sample mem_rdata.
  - Merge: sb replaces byte byte_off with wdata[7:0]; sh replaces the halfword at addr[1] with wdata[15:0].
  - Merged word goes to mem_wdata; next state WR.
- WR:
  - mem_we=1 for exactly this one cycle, with mem_addr and mem_wdata stable the whole cycle.
  - For sw, mem_wdata = wdata unmodified.
  - Next state DONE.
- DONE:
  - resp_valid=1 for one cycle; resp_rdata and resp_err hold their final values.
  - resp_rdata = 0 for stores.
  - Next state IDLE.
  - resp_rdata and resp_err hold their values after the pulse until the next response.
- Latency (accept edge to resp_valid high):
  - Loads: 2 cycles.
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- Throughput: IDLE is revisited between requests, so back-to-back requests are spaced by latency + 1 cycles. req_ready is low in all non-IDLE states.
- mem_we is low in every state except WR.
- Reset mid-operation: the FSM goes to IDLE on that edge, mem_we drops, and no response is issued. A partial RMW never writes.
- A request held while req_ready=0 is not accepted; the core must keep req_valid asserted.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- When defined, adds three outputs:
  - load_cnt [31:0]
  - store_cnt [31:0]
  - err_cnt [31:0]
- Each counter increments by 1 in the DONE cycle of the matching completed response:
  - Errors count only in err_cnt.
  - Loads count only in load_cnt; stores only in store_cnt.
- Counters clear on rst and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Memory word 3 = 0x8899AABB; lb addr 0x0E -> resp_valid 2 cycles after accept, resp_rdata 0xFFFFFF99, resp_err 0.
- Same word; lhu addr 0x0C -> 0x0000AABB. lh addr 0x0E -> 0xFFFF8899.
- sb addr 0x0D wdata 0x123456CC onto word 3 = 0x8899AABB -> single mem_we pulse at index 3 with mem_wdata 0x8899CCBB; resp_valid 3 cycles after accept.
- sw addr 0x104 (MEM_AW=6) -> wraps to index 1, mem_wdata = req_wdata, resp_valid after 2 cycles.
- lw addr 0x02, sh addr 0x01, funct3 011 -> each gives resp_err=1 after 1 cycle with mem_we never high. With LSU_PERF_CNT_EN, err_cnt=3.
- Assert rst in the RMW_RD cycle of an sb -> no mem_we, no resp_valid, req_ready=1 next cycle. Next lw completes normally.
